// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared types and helpers for the load/store front end.
//   - mem_funct3_t : RV32I load width/sign encodings. Stores reuse the same
//                    codes (SB=000, SH=001, SW=010).
//   - mem_state_t  : access sequencer states.
//   - funct3_illegal / access_misaligned : request screening run in IDLE.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    MERGE,
    WR_ISSUE,
    WR_WAIT,
    FINISH
  } mem_state_t;

  // 011/110/111 are never valid; the unsigned variants 100/101 only exist
  // for loads, so a store carrying them is rejected as well.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
  endfunction

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  // Only called for encodings that already passed funct3_illegal.
  function automatic logic access_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    logic bad;
    case (funct3[1:0])
      2'b10:   bad = (addr_lo != 2'b00);
      2'b01:   bad = addr_lo[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// ---------------------------------------------------------------------------
// load_store_align
//   Purely combinational lane steering for sub-word accesses.
//   Load path : picks the byte/halfword selected by addr[1:0] from a RAM word
//               and sign- or zero-extends it according to funct3.
//   Store path: overlays the low store bits onto the old word at the lane
//               selected by addr[1:0] (SB) or addr[1] (SH); SW passes the
//               store data through untouched.
//   Ports:
//     load_word, load_addr_lo, load_funct3  -> load_result
//     old_word, store_data, store_addr_lo, store_funct3 -> merged_word
// ---------------------------------------------------------------------------
module load_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [1:0]  load_addr_lo,
  input  logic [2:0]  load_funct3,
  output logic [31:0] load_result,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  store_addr_lo,
  input  logic [2:0]  store_funct3,
  output logic [31:0] merged_word
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte   = 8'h00;
    load_half   = 16'h0000;
    load_result = 32'h0000_0000;

    case (load_addr_lo)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase

    load_half = load_addr_lo[1] ? load_word[31:16] : load_word[15:0];

    case (load_funct3)
      LB:      load_result = {{24{load_byte[7]}}, load_byte};
      LBU:     load_result = {24'h000000, load_byte};
      LH:      load_result = {{16{load_half[15]}}, load_half};
      LHU:     load_result = {16'h0000, load_half};
      LW:      load_result = load_word;
      default: load_result = 32'h0000_0000;
    endcase
  end

  always_comb begin
    merged_word = store_data;

    case (store_funct3)
      3'b000: begin
        case (store_addr_lo)
          2'd0:    merged_word = {old_word[31:8], store_data[7:0]};
          2'd1:    merged_word = {old_word[31:16], store_data[7:0], old_word[7:0]};
          2'd2:    merged_word = {old_word[31:24], store_data[7:0], old_word[15:0]};
          default: merged_word = {store_data[7:0], old_word[23:0]};
        endcase
      end
      3'b001: begin
        merged_word = store_addr_lo[1] ? {store_data[15:0], old_word[15:0]}
                                       : {old_word[31:16], store_data[15:0]};
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store front end sitting between the core memory stage and
//   ram_control. Takes one RV32I load/store, screens it (funct3 legality,
//   alignment, range), then runs the word-level ram_control handshake.
//   Sub-word stores are done as read-modify-write; sub-word loads are
//   extracted and extended before being returned.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     mem_req               request strobe, only looked at in IDLE
//     mem_we                1 = store, 0 = load
//     mem_funct3            RV32I width/sign encoding
//     mem_addr              byte address
//     mem_wr_data           store data (low bytes for SB/SH)
//     mem_rd_data           extended load result, held until next load
//     mem_done              one-cycle completion pulse
//     mem_fault             qualifies mem_done: request was rejected
//     mem_busy              high whenever the sequencer is not IDLE
//     ram_rd_start/ram_wr_start        one-cycle start pulses
//     ram_rd_addr_base/ram_wr_addr_base 16-bit-entry index of the word
//     ram_wr_data_in        full word to write
//     ram_rd_done/ram_wr_done          completion pulses from ram_control
//     ram_rd_data_out       read word, valid with ram_rd_done
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_WORDS  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [2:0]            mem_funct3,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wr_data,
  output logic [31:0]           mem_rd_data,
  output logic                  mem_done,
  output logic                  mem_fault,
  output logic                  mem_busy,
  output logic                  ram_wr_start,
  output logic                  ram_rd_start,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_base,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_base,
  output logic [31:0]           ram_wr_data_in,
  input  logic                  ram_wr_done,
  input  logic                  ram_rd_done,
  input  logic [31:0]           ram_rd_data_out
);

  localparam logic [63:0] RAM_BYTES = 64'(RAM_WORDS) * 64'd4;

  mem_state_t            state;
  logic                  lat_we;
  logic [2:0]            lat_funct3;
  logic [1:0]            lat_addr_lo;
  logic [31:0]           lat_store_data;
  logic [31:0]           rd_word;
  logic [ADDR_WIDTH-1:0] addr_base;

  logic                  req_fault;
  logic [31:0]           load_result;
  logic [31:0]           merged_word;

  // Screening is done on the live request inputs so a rejected access can
  // complete one cycle after it was sampled.
  assign req_fault = funct3_illegal(mem_we, mem_funct3)
                  || access_misaligned(mem_funct3, mem_addr[1:0])
                  || (64'(mem_addr) >= RAM_BYTES);

  assign mem_busy         = (state != IDLE);
  assign ram_wr_addr_base = addr_base;
  assign ram_rd_addr_base = addr_base;

  // The load path works on the word arriving from ram_control in the done
  // cycle, so the extended result is registered together with mem_done.
  // The store path merges into the word captured by the read phase.
  load_store_align u_align (
    .load_word     (ram_rd_data_out),
    .load_addr_lo  (lat_addr_lo),
    .load_funct3   (lat_funct3),
    .load_result   (load_result),
    .old_word      (rd_word),
    .store_data    (lat_store_data),
    .store_addr_lo (lat_addr_lo),
    .store_funct3  (lat_funct3),
    .merged_word   (merged_word)
  );

  // Access sequencer. Every output pulse is raised on the edge that enters
  // the state it belongs to and dropped on the edge that leaves it, so the
  // pulses line up exactly with RD_ISSUE, WR_ISSUE and FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_we         <= 1'b0;
      lat_funct3     <= 3'b000;
      lat_addr_lo    <= 2'b00;
      lat_store_data <= 32'h0000_0000;
      rd_word        <= 32'h0000_0000;
      addr_base      <= '0;
      mem_rd_data    <= 32'h0000_0000;
      mem_done       <= 1'b0;
      mem_fault      <= 1'b0;
      ram_wr_start   <= 1'b0;
      ram_rd_start   <= 1'b0;
      ram_wr_data_in <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            lat_we         <= mem_we;
            lat_funct3     <= mem_funct3;
            lat_addr_lo    <= mem_addr[1:0];
            lat_store_data <= mem_wr_data;
            if (req_fault) begin
              mem_done  <= 1'b1;
              mem_fault <= 1'b1;
              if (!mem_we) begin
                mem_rd_data <= 32'h0000_0000;
              end
              state <= FINISH;
            end else begin
              addr_base <= {1'b0, mem_addr[ADDR_WIDTH-1:2], 1'b0};
              // SW shares the LW encoding and needs no read phase.
              if (mem_we && (mem_funct3 == LW)) begin
                ram_wr_data_in <= mem_wr_data;
                ram_wr_start   <= 1'b1;
                state          <= WR_ISSUE;
              end else begin
                ram_rd_start <= 1'b1;
                state        <= RD_ISSUE;
              end
            end
          end
        end

        // A done in the issue cycle itself is treated like one in RD_WAIT.
        RD_ISSUE, RD_WAIT: begin
          ram_rd_start <= 1'b0;
          if (ram_rd_done) begin
            rd_word <= ram_rd_data_out;
            if (lat_we) begin
              state <= MERGE;
            end else begin
              mem_rd_data <= load_result;
              mem_done    <= 1'b1;
              mem_fault   <= 1'b0;
              state       <= FINISH;
            end
          end else begin
            state <= RD_WAIT;
          end
        end

        MERGE: begin
          ram_wr_data_in <= merged_word;
          ram_wr_start   <= 1'b1;
          state          <= WR_ISSUE;
        end

        WR_ISSUE, WR_WAIT: begin
          ram_wr_start <= 1'b0;
          if (ram_wr_done) begin
            mem_done  <= 1'b1;
            mem_fault <= 1'b0;
            state     <= FINISH;
          end else begin
            state <= WR_WAIT;
          end
        end

        FINISH: begin
          mem_done  <= 1'b0;
          mem_fault <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          mem_done     <= 1'b0;
          mem_fault    <= 1'b0;
          ram_wr_start <= 1'b0;
          ram_rd_start <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Bench for mem_access_unit with a behavioural ram_control stand-in
//   (4096 x 16-bit entries, programmable read/write latency). Each request
//   pushes its hand-computed response onto a queue; an independent monitor
//   pops and compares whenever mem_done is seen.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mem_req;
  logic                  mem_we;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wr_data;
  logic [31:0]           mem_rd_data;
  logic                  mem_done;
  logic                  mem_fault;
  logic                  mem_busy;
  logic                  ram_wr_start;
  logic                  ram_rd_start;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_base;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_base;
  logic [31:0]           ram_wr_data_in;
  logic                  ram_wr_done;
  logic                  ram_rd_done;
  logic [31:0]           ram_rd_data_out;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_WORDS  (2048)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_funct3       (mem_funct3),
    .mem_addr         (mem_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_rd_data      (mem_rd_data),
    .mem_done         (mem_done),
    .mem_fault        (mem_fault),
    .mem_busy         (mem_busy),
    .ram_wr_start     (ram_wr_start),
    .ram_rd_start     (ram_rd_start),
    .ram_wr_addr_base (ram_wr_addr_base),
    .ram_rd_addr_base (ram_rd_addr_base),
    .ram_wr_data_in   (ram_wr_data_in),
    .ram_wr_done      (ram_wr_done),
    .ram_rd_done      (ram_rd_done),
    .ram_rd_data_out  (ram_rd_data_out)
  );

  // Behavioural RAM: latency N means done is high N cycles after the start
  // cycle; N = 0 answers combinationally in the start cycle.
  logic [15:0] ram [0:4095];
  int   rd_lat = 2;
  int   wr_lat = 2;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic rd_done_q = 1'b0;
  logic wr_done_q = 1'b0;
  logic stray_rd  = 1'b0;
  int   rd_starts = 0;
  int   wr_starts = 0;
  int   cycle_cnt = 0;

  assign ram_rd_done     = rd_done_q | (ram_rd_start && rd_lat == 0) | stray_rd;
  assign ram_wr_done     = wr_done_q | (ram_wr_start && wr_lat == 0);
  assign ram_rd_data_out = {ram[ram_rd_addr_base[11:0] | 12'd1], ram[ram_rd_addr_base[11:0]]};

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
  end

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (ram_rd_start) rd_starts <= rd_starts + 1;
    if (ram_wr_start) wr_starts <= wr_starts + 1;

    rd_done_q <= 1'b0;
    if (ram_rd_start && rd_lat > 0) begin
      if (rd_lat == 1) rd_done_q <= 1'b1;
      else rd_cnt <= rd_lat - 1;
    end else if (rd_cnt > 0) begin
      if (rd_cnt == 1) rd_done_q <= 1'b1;
      rd_cnt <= rd_cnt - 1;
    end

    wr_done_q <= 1'b0;
    if (ram_wr_start && wr_lat > 0) begin
      if (wr_lat == 1) wr_done_q <= 1'b1;
      else wr_cnt <= wr_lat - 1;
    end else if (wr_cnt > 0) begin
      if (wr_cnt == 1) wr_done_q <= 1'b1;
      wr_cnt <= wr_cnt - 1;
    end

    if (ram_wr_done) begin
      ram[ram_wr_addr_base[11:0]]         <= ram_wr_data_in[15:0];
      ram[ram_wr_addr_base[11:0] | 12'd1] <= ram_wr_data_in[31:16];
    end
  end

  // Scoreboard
  typedef struct {
    string       name;
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          issue;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   passes     = 0;
  int   done_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Monitor: every mem_done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_done === 1'b1) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_done: got mem_done=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          checkOutput({e.name, "_fault"}, 32'(mem_fault), 32'(e.fault));
          checkOutput({e.name, "_data"}, mem_rd_data, e.data);
          checkOutput({e.name, "_latency"}, 32'(cycle_cnt + 1 - e.issue), 32'(e.lat));
        end
      end
    end
  end

  // Issue one request, record what must come back, and wait (bounded) for
  // its completion. With hold set, mem_req stays high until mem_done.
  task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] exp_data, input logic exp_fault,
                               input int exp_lat, input bit hold);
    exp_t e;
    bit   got;
    @(negedge clk);
    mem_we      = we;
    mem_funct3  = f3;
    mem_addr    = addr;
    mem_wr_data = data;
    mem_req     = 1'b1;
    @(posedge clk);
    #1;
    e.name  = name;
    e.data  = exp_data;
    e.fault = exp_fault;
    e.lat   = exp_lat;
    e.issue = cycle_cnt;
    exp_q.push_back(e);
    if (!hold) mem_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    mem_req = 1'b0;
    if (!got) begin
      checks++;
      $display("[TB] FAIL %s_timeout: got no mem_done in 60 cycles, expected one", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd0, wr0, dc0;
    reset       = 1'b1;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_funct3  = 3'b000;
    mem_addr    = '0;
    mem_wr_data = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rd_data", mem_rd_data, 32'h0);
    checkOutput("reset_ctrl", 32'({mem_done, mem_fault, mem_busy, ram_wr_start, ram_rd_start}), 32'h0);
    checkOutput("reset_wr_data_in", ram_wr_data_in, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] word store and sub-word loads at top of RAM");
    applyStimulus("sw_1ff8", 1'b1, 3'b010, 32'h1FF8, 32'hAABBCCDD, 32'h0, 1'b0, 4, 1'b0);
    checkOutput("sw_addr_base", ram_wr_addr_base, 32'd4092);
    checkOutput("sw_entry_4092", 32'(ram[4092]), 32'h0000CCDD);
    checkOutput("sw_entry_4093", 32'(ram[4093]), 32'h0000AABB);
    checkOutput("sw_rd_starts", 32'(rd_starts), 32'd0);
    applyStimulus("lw_1ff8",  1'b0, 3'b010, 32'h1FF8, 32'h0, 32'hAABBCCDD, 1'b0, 4, 1'b0);
    applyStimulus("lb_1ffb",  1'b0, 3'b000, 32'h1FFB, 32'h0, 32'hFFFFFFAA, 1'b0, 4, 1'b0);
    applyStimulus("lbu_1ffb", 1'b0, 3'b100, 32'h1FFB, 32'h0, 32'h000000AA, 1'b0, 4, 1'b0);
    applyStimulus("lh_1ff8",  1'b0, 3'b001, 32'h1FF8, 32'h0, 32'hFFFFCCDD, 1'b0, 4, 1'b0);
    applyStimulus("lhu_1ffa", 1'b0, 3'b101, 32'h1FFA, 32'h0, 32'h0000AABB, 1'b0, 4, 1'b0);

    $display("[TB] byte store read-modify-write");
    rd0 = rd_starts;
    wr0 = wr_starts;
    applyStimulus("sb_1ff9", 1'b1, 3'b000, 32'h1FF9, 32'h00000011, 32'h0000AABB, 1'b0, 8, 1'b0);
    checkOutput("sb_rd_pulses", 32'(rd_starts - rd0), 32'd1);
    checkOutput("sb_wr_pulses", 32'(wr_starts - wr0), 32'd1);
    applyStimulus("lw_after_sb", 1'b0, 3'b010, 32'h1FF8, 32'h0, 32'hAABB11DD, 1'b0, 4, 1'b0);

    $display("[TB] zero-latency ram_control");
    rd_lat = 0;
    wr_lat = 0;
    applyStimulus("sh_1ffa_lat0", 1'b1, 3'b001, 32'h1FFA, 32'h00001234, 32'hAABB11DD, 1'b0, 4, 1'b0);
    applyStimulus("lw_lat0",      1'b0, 3'b010, 32'h1FF8, 32'h0, 32'h123411DD, 1'b0, 2, 1'b0);
    applyStimulus("lb_1ff9_lat0", 1'b0, 3'b000, 32'h1FF9, 32'h0, 32'h00000011, 1'b0, 2, 1'b0);
    rd_lat = 2;
    wr_lat = 2;

    $display("[TB] faulting requests");
    rd0 = rd_starts;
    wr0 = wr_starts;
    applyStimulus("lw_misaligned", 1'b0, 3'b010, 32'h1FF9, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("sh_misaligned", 1'b1, 3'b001, 32'h0003, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("lw_range",      1'b0, 3'b010, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("f3_011",        1'b0, 3'b011, 32'h0000, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("store_f3_100",  1'b1, 3'b100, 32'h0000, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    checkOutput("fault_starts", 32'((rd_starts - rd0) + (wr_starts - wr0)), 32'd0);

    $display("[TB] request held high through a store");
    wr0 = wr_starts;
    applyStimulus("sw_held", 1'b1, 3'b010, 32'h0000, 32'h01020304, 32'h0, 1'b0, 4, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("held_wr_pulses", 32'(wr_starts - wr0), 32'd1);
    checkOutput("held_entry_0", 32'(ram[0]), 32'h00000304);
    checkOutput("held_entry_1", 32'(ram[1]), 32'h00000102);
    applyStimulus("lw_before_reset", 1'b0, 3'b010, 32'h1FF8, 32'h0, 32'h123411DD, 1'b0, 4, 1'b0);

    $display("[TB] reset during read wait");
    rd_lat = 6;
    @(negedge clk);
    mem_we     = 1'b0;
    mem_funct3 = 3'b010;
    mem_addr   = 32'h1FF8;
    mem_req    = 1'b1;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(mem_busy), 32'd1);
    dc0   = done_count;
    reset = 1'b1;
    #1;
    checkOutput("abort_rd_data", mem_rd_data, 32'h0);
    checkOutput("abort_ctrl", 32'({mem_done, mem_fault, mem_busy, ram_wr_start, ram_rd_start}), 32'h0);
    checkOutput("abort_addr_base", ram_rd_addr_base, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stray_rd = 1'b1;
    @(negedge clk);
    stray_rd = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("stray_done_count", 32'(done_count - dc0), 32'd0);
    checkOutput("stray_busy", 32'(mem_busy), 32'd0);

    rd_lat = 1;
    applyStimulus("lw_recover", 1'b0, 3'b010, 32'h1FF8, 32'h0, 32'h123411DD, 1'b0, 3, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL leftover_expectations: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
